// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the eight-digit seven-segment scanner
package seg_pkg;
  localparam int NUM_DIGITS = 8;
  typedef struct packed {
    logic       dp;
    logic       blank;
    logic [3:0] hex;
  } digit_t;
  localparam digit_t BLANK_DIGIT = '{dp: 1'b0, blank: 1'b1, hex: 4'h0};
  localparam logic [7:0] SEG_CODE [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };
  typedef enum logic {BLANK, SHOW} state_t;
endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational digit entry to {a,b,c,d,e,f,g,dp} segment pattern
module seg_decode
  import seg_pkg::*;
(
  input  digit_t     d,
  output logic [7:0] seg
);
  logic [7:0] code;
  assign code = SEG_CODE[d.hex];
  assign seg  = {d.blank ? 7'd0 : code[7:1], d.dp};
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 8-digit scan with shadow/active buffers; SEG_LZS_EN enables leading-zero suppression
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       disp_en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic       commit,
  output logic       pending,
  output logic       frame_tick,
  output logic [7:0] seg_en,
  output logic [7:0] seg_out0,
  output logic [7:0] seg_out1
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST     = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);
  logic [CW-1:0]         cnt;
  logic [2:0]            idx;
  state_t                state, state_n;
  digit_t                shadow [NUM_DIGITS];
  digit_t                active [NUM_DIGITS];
  logic                  slot_end, copy;
  logic [NUM_DIGITS-1:0] dark;
  digit_t                cur;
  logic [7:0]            seg;
  assign slot_end = cnt == LAST;
  assign copy     = frame_tick & (pending | commit);
  // slot counter and digit index; disabled display parks at digit 0, count 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!disp_en) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      idx <= slot_end ? idx + 1'b1 : idx;
    end
  // scan state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BLANK;
    else        state <= state_n;
  // dead time at the start of each slot, then show until the slot wraps
  always_comb begin
    state_n = state;
    state_n = !disp_en                               ? BLANK :
              (state == BLANK && cnt == BLK_LAST)    ? SHOW  :
              (state == SHOW  && slot_end)           ? BLANK : state;
  end
  // shadow writes, frame-aligned copy to active (pre-write shadow), commit handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= BLANK_DIGIT;
        active[i] <= BLANK_DIGIT;
      end
      pending <= 1'b0;
    end else begin
      if (wr_en) shadow[wr_addr] <= digit_t'(wr_data);
      if (copy)  active <= shadow;
      pending <= (pending | commit) & ~copy;
    end
`ifdef SEG_LZS_EN
  logic run;
  // a digit goes dark while it and every higher digit are plain zero; digit 0 never does
  always_comb begin
    dark = '0;
    run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run     = run & (active[i] == '0);
      dark[i] = run;
    end
  end
`else
  assign dark = '0;
`endif
  assign cur = dark[idx] ? BLANK_DIGIT : active[idx];
  seg_decode u_dec (.d(cur), .seg(seg));
  // registered pins: one digit select and its group bus during SHOW only
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_tick <= 1'b0;
      seg_en     <= '0;
      seg_out0   <= '0;
      seg_out1   <= '0;
    end else begin
      frame_tick <= disp_en & slot_end & (idx == 3'd7);
      seg_en     <= (disp_en && state == SHOW) ? 8'd1 << idx : 8'd0;
      seg_out0   <= (disp_en && state == SHOW && idx[2])  ? seg : 8'd0;
      seg_out1   <= (disp_en && state == SHOW && !idx[2]) ? seg : 8'd0;
    end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100000, SHALL set the clk cycles per digit slot (legal range 4..2^20).
REQ-002 Parameter BLANK_CYC, default 1000, SHALL set the dead-time cycles at the start of each slot; it SHALL satisfy 1 <= BLANK_CYC < SCAN_DIV.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 disp_en  input  1  high = display running; low = outputs dark and scan restarted.
REQ-006 wr_en  input  1  one-cycle write strobe into the shadow buffer.
REQ-007 wr_addr  input  3  digit index 0..7 to write.
REQ-008 wr_data  input  6  {dp, blank, hex[3:0]} for the digit.
REQ-009 commit  input  1  one-cycle request to copy the shadow buffer to the active buffer.
REQ-010 pending  output  1  commit requested but not yet applied.
REQ-011 frame_tick  output  1  one-cycle pulse at the end of the digit-7 slot.
REQ-012 seg_en  output  8  one-hot digit select, active-high; bit n = digit n.
REQ-013 seg_out0  output  8  segments for digits 4..7, {a,b,c,d,e,f,g,dp}, active-high.
REQ-014 seg_out1  output  8  segments for digits 0..3, same encoding.

Function
REQ-015 A slot counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index idx SHALL advance 0->1->...->7->0.
REQ-016 FSM SHALL have two states: BLANK for slot counts 0..BLANK_CYC-1, SHOW for counts BLANK_CYC..SCAN_DIV-1.
REQ-017 In BLANK: seg_en, seg_out0 and seg_out1 SHALL all be 0.
REQ-018 In SHOW: seg_en SHALL be 1<<idx. The group bus owning idx SHALL carry decode(active[idx]); the other bus SHALL be 0.
REQ-019 Decode: hex 0..F SHALL map to the standard codes (0=FC, 1=60, ..., 8=FE, F=8E). Bit 0 SHALL equal dp. blank=1 SHALL force segments a..g to 0, while dp SHALL still be honoured.
REQ-020 All outputs SHALL be registered, with 1-cycle latency from counter state to pins.
REQ-021 wr_en SHALL write wr_data into shadow[wr_addr] on the next edge and SHALL never alter the active buffer directly.
REQ-022 commit SHALL set pending. On the frame_tick cycle with pending=1, active SHALL take shadow in one cycle and pending SHALL clear.
REQ-023 commit asserted on the frame_tick cycle SHALL be applied at that same boundary.
REQ-024 wr_en on the copy cycle SHALL land in shadow only; the copy SHALL use the pre-write shadow.
REQ-025 A commit while pending=1 SHALL be absorbed and SHALL NOT queue a second copy.
REQ-026 disp_en low SHALL zero all three display outputs on the next cycle and SHALL hold the counter at 0 and idx at 0 in BLANK. frame_tick SHALL stay 0 and buffers/pending SHALL be retained. On re-enable, scanning SHALL restart from digit 0 BLANK.

Reset
REQ-027 rst_n low SHALL immediately force seg_en=0, seg_out0=0, seg_out1=0, frame_tick=0 and pending=0.
REQ-028 rst_n low SHALL clear the slot counter, set idx=0 and enter BLANK.
REQ-029 rst_n low SHALL load every shadow and active entry with 6'b010000 (blank, no dp).
REQ-030 Reset mid-slot or mid-pending SHALL discard the pending commit.

Configuration
REQ-031 With SEG_LZS_EN defined, active digits 7 down to 1 SHALL be displayed dark while they and all higher digits hold hex 0, blank 0 and dp 0. Digit 0 SHALL always be shown.
REQ-032 Without SEG_LZS_EN, every digit SHALL display its active entry as-is.

Structure
REQ-033 Package seg_pkg SHALL hold: NUM_DIGITS=8, the digit-entry typedef {dp, blank, hex}, the segment-code constants for 0..F, and the FSM state enum.
REQ-034 Sub-module seg_decode SHALL be the purely combinational entry-to-segment decoder, instantiated once.

Verification (SCAN_DIV=8, BLANK_CYC=2, disp_en=1)
REQ-035 Reset release, no writes: seg_en cycles 01,02,...,80 with 6 SHOW cycles per slot; seg_out0/1 stay 00; frame_tick every 64 cycles.
REQ-036 Write addr 0 = hex 3, commit: pending=1 until next frame_tick. After it, digit-0 SHOW gives seg_out1=F2 and seg_out0=00; the first 2 cycles of each slot show seg_en=00.
REQ-037 Write addr 5 = 6'b10_1010 then commit on the frame_tick cycle: the same boundary applies; digit-5 SHOW gives seg_out0=EF.
REQ-038 Write on the copy cycle: the new value appears only after the next commit plus frame boundary.
REQ-039 disp_en low mid-slot of digit 4: outputs 00 on the next cycle. On re-enable, the first seg_en is 01 after 2 BLANK cycles.
REQ-040 SEG_LZS_EN, active = 0,0,0,0,0,1,0,0 (digits 7..0): digits 7..3 dark; digits 2,1,0 show 60,FC,FC.
